// File: rtl/rv32_data_ram.sv
// rv32_data_ram: word-addressed, byte-maskable RAM answering the core's data
// memory bus. One request at a time, LATENCY cycles from the sampling edge to
// a single-cycle ready_out pulse, with out-of-range accesses flagged on fault_out.
module rv32_data_ram #(
  parameter int          DEPTH_WORDS  = 1024,
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
  parameter int          LATENCY      = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address_in,
  input  logic        read_in,
  input  logic        write_in,
  input  logic [3:0]  write_mask_in,
  input  logic [31:0] write_value_in,
  output logic [31:0] read_value_out,
  output logic        ready_out,
  output logic        fault_out
);

  localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_W   = 32'(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Replace only the bytes whose enable bit is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) begin
        res[8*b +: 8] = new_word[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_word[8*b +: 8];
      end
    end
    return res;
  endfunction

  state_t          state_r;
  state_t          state_nxt_s;
  logic [3:0]      count_r;
  logic [3:0]      count_nxt_s;

  logic [AW-1:0]   lat_idx_r;
  logic            lat_oor_r;
  logic            lat_read_r;
  logic            lat_write_r;
  logic [3:0]      lat_mask_r;
  logic [31:0]     lat_wdata_r;

  logic [31:0]     offset_s;
  logic [31:0]     word_off_s;
  logic            req_oor_s;
  logic [AW-1:0]   req_idx_s;

  logic [AW-1:0]   eff_idx_s;
  logic            eff_oor_s;
  logic            eff_read_s;
  logic            eff_write_s;
  logic [3:0]      eff_mask_s;
  logic [31:0]     eff_wdata_s;
  logic            enter_done_s;
  logic            mem_we_s;

  logic [31:0]     mem_r [DEPTH_WORDS];
  logic [31:0]     read_value_r;
  logic            ready_r;
  logic            fault_r;

  // Unsigned wrap makes addresses below the base land far above the window.
  assign offset_s   = address_in - BASE_ADDRESS;
  assign word_off_s = offset_s >> 2;
  assign req_oor_s  = (word_off_s >= DEPTH_W);
  assign req_idx_s  = word_off_s[AW-1:0];

  // Next-state and wait-counter logic of the IDLE/WAIT/DONE sequencer.
  always_comb begin
    state_nxt_s = state_r;
    count_nxt_s = count_r;
    case (state_r)
      ST_IDLE: begin
        if (read_in | write_in) begin
          if (LATENCY == 1) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_WAIT;
            count_nxt_s = WAIT_LOAD;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (count_r == 4'd0) begin
          state_nxt_s = ST_DONE;
        end else begin
          count_nxt_s = count_r - 4'd1;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        count_nxt_s = 4'd0;
      end
    endcase
  end

  // In IDLE the request comes straight off the bus (single-cycle case); otherwise use the latched copy.
  always_comb begin
    eff_idx_s   = lat_idx_r;
    eff_oor_s   = lat_oor_r;
    eff_read_s  = lat_read_r;
    eff_write_s = lat_write_r;
    eff_mask_s  = lat_mask_r;
    eff_wdata_s = lat_wdata_r;
    if (state_r == ST_IDLE) begin
      eff_idx_s   = req_idx_s;
      eff_oor_s   = req_oor_s;
      eff_read_s  = read_in;
      eff_write_s = write_in;
      eff_mask_s  = write_mask_in;
      eff_wdata_s = write_value_in;
    end else begin
      eff_idx_s   = lat_idx_r;
      eff_oor_s   = lat_oor_r;
      eff_read_s  = lat_read_r;
      eff_write_s = lat_write_r;
      eff_mask_s  = lat_mask_r;
      eff_wdata_s = lat_wdata_r;
    end
  end

  // A write lands only on the edge entering DONE and never while reset is held.
  assign enter_done_s = (state_nxt_s == ST_DONE);
  assign mem_we_s     = enter_done_s & eff_write_s & ~eff_oor_s & ~reset;

  // Sequencer state, latched request and registered bus outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      count_r      <= 4'd0;
      lat_idx_r    <= '0;
      lat_oor_r    <= 1'b0;
      lat_read_r   <= 1'b0;
      lat_write_r  <= 1'b0;
      lat_mask_r   <= 4'd0;
      lat_wdata_r  <= 32'h0;
      read_value_r <= 32'h0;
      ready_r      <= 1'b0;
      fault_r      <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      count_r <= count_nxt_s;
      if ((state_r == ST_IDLE) && (read_in | write_in)) begin
        lat_idx_r   <= req_idx_s;
        lat_oor_r   <= req_oor_s;
        lat_read_r  <= read_in;
        lat_write_r <= write_in;
        lat_mask_r  <= write_mask_in;
        lat_wdata_r <= write_value_in;
      end
      if (enter_done_s) begin
        if (eff_write_s) begin
          if (eff_read_s) begin
            read_value_r <= 32'h0;
          end
        end else if (eff_oor_s) begin
          read_value_r <= 32'h0;
        end else begin
          read_value_r <= mem_r[eff_idx_s];
        end
      end
      ready_r <= enter_done_s;
      fault_r <= enter_done_s & eff_oor_s;
    end
  end

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[eff_idx_s] <= merge_bytes(mem_r[eff_idx_s], eff_wdata_s, eff_mask_s);
    end
  end

  assign read_value_out = read_value_r;
  assign ready_out      = ready_r;
  assign fault_out      = fault_r;

endmodule

// File: doc/rv32_data_ram.md
# rv32_data_ram

Word-addressed, byte-maskable RAM that acts as the responder on the core's data memory bus. It accepts one read or write request at a time, inserts a programmable number of wait cycles, and signals completion with a single-cycle `ready_out` pulse. It sits outside the core, on the `data_*` port group. It also serves as the bench memory model and as the FPGA on-chip RAM.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words; power of two, ≥ 2.
- `BASE_ADDRESS`, 32'h0000_0000: byte address of word 0; aligned to `4*DEPTH_WORDS`.
- `LATENCY`, 1: cycles from the request-sampling edge to `ready_out` high; legal range 1..16.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `address_in`  in  32  byte address; bits [1:0] ignored.
- `read_in`  in  1  read request.
- `write_in`  in  1  write request.
- `write_mask_in`  in  4  byte enables; bit i selects bits [8i+7:8i].
- `write_value_in`  in  32  write data.
- `read_value_out`  out  32  read data; valid while `ready_out` is high after a read.
- `ready_out`  out  1  one-cycle completion pulse.
- `fault_out`  out  1  high together with `ready_out` when the access is out of range.

## Operation
- States are IDLE, WAIT and DONE. Reset puts the block in IDLE.
- **IDLE:**
  - If `read_in | write_in` is high at an edge, latch the address, the op, the mask and the write value.
  - If `LATENCY == 1`, go to DONE. Otherwise go to WAIT with `count = LATENCY-2`.
- **WAIT:**
  - When `count == 0`, go to DONE. Otherwise decrement `count`.
  - Request inputs are ignored in WAIT.
- **Edge entering DONE:**
  - For a write, commit the masked bytes to the latched word.
  - For a read, register the word into `read_value_out`.
- **DONE:**
  - `ready_out` = 1.
  - `fault_out` = latched out-of-range flag.
  - Go to IDLE unconditionally. The request still on the bus in DONE belongs to the finished transfer and is never re-sampled.
- **Range check:**
  - In range means `address_in - BASE_ADDRESS < 4*DEPTH_WORDS` (unsigned 32-bit).
  - Word index = `(address_in - BASE_ADDRESS) >> 2`, truncated to log2(`DEPTH_WORDS`) bits.
  - Out of range: a write changes nothing, a read returns 32'h0, and `fault_out` pulses with `ready_out`.
- `read_in` and `write_in` high together: treated as a write, and `read_value_out` is updated to 32'h0.
- A write with `write_mask_in == 4'b0000` completes normally and changes no byte.
- Once a request is latched, the transfer always completes, even if the initiator drops its request mid-WAIT. A write is still committed in that case.

## Timing
- **Reset values:**
  - `ready_out` = 0, `fault_out` = 0, `read_value_out` = 32'h0, state IDLE, `count` = 0.
  - Memory contents are not cleared.
- **Reset asserted mid-transfer:** return to IDLE immediately with outputs at their reset values. A write that has not yet reached DONE is never committed.
- **Latency:** request sampled at edge E; `ready_out` is high in the cycle after edge E+`LATENCY`-1.
- **Throughput:** one access per `LATENCY+1` cycles. The minimum spacing between `ready_out` pulses is `LATENCY+1`.
- **Handshake:**
  - The initiator holds the request stable until it sees `ready_out`.
  - It may present a new request in the cycle after DONE, which is sampled from IDLE.
- **`read_value_out` hold:** it holds its last value outside DONE and changes only on edges entering DONE.
- **`ready_out` and `fault_out`:** both are registered and never high outside DONE.

## Test plan
- **Basic round trip** (`LATENCY=1`, `BASE=0`):
  - Write 32'hDEADBEEF, mask 4'hF, to 0x10 → `ready_out` pulses one cycle after the sampling edge.
  - Read 0x10 → `read_value_out` = 32'hDEADBEEF with `ready_out`; `fault_out` = 0.
- **Byte masking:** preload 32'h11223344 at 0x20, write 32'hAABBCCDD with mask 4'b0101, then read 0x20 → 32'h11BB33DD.
- **Wait states** (`LATENCY=4`): read request at edge E → `ready_out` high only in the cycle after E+3, and the next sampled request no earlier than edge E+5.
- **Out of range** (`BASE=32'h1000_0000`, `DEPTH=1024`):
  - Write 0x1000_1000 → `fault_out` = 1 with `ready_out`; contents unchanged.
  - Read 0x0FFF_FFFC → 32'h0 with `fault_out` = 1.
- **Reset mid-write** (`LATENCY=4`): assert `reset` two cycles after write sampling → no `ready_out`, and a later read of that word returns the old value.
- **Dropped request and dual op:**
  - Drop `write_in` during WAIT → write still committed and `ready_out` still pulses.
  - `read_in` and `write_in` both high → word written and `read_value_out` = 32'h0.
